// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   STATE_W : width of the controller state register
//   state_t : controller states (IDLE, LOAD, ADD, SHIFT, DONE)
// Optional feature macro used by the multiplier: SEQ_MULT_SIGNED_EN
// ---------------------------------------------------------------------------
package seq_mult_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage : seq_mult_pkg

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
// Controller FSM for the shift-add multiplier. Holds no datapath state; it
// only sequences the LOAD / ADD / SHIFT / DONE steps from status bits
// reported by the datapath.
// Ports:
//   clk        : system clock, rising edge
//   clr_n      : asynchronous active-low reset
//   start      : operation request, honoured only in IDLE
//   b_zero_now : current multiplier register is zero
//   b_lsb_now  : current multiplier register bit 0
//   bn_zero    : multiplier register shifted right by one is zero
//   bn_lsb     : bit 0 of the shifted multiplier register
//   load       : capture operands into the datapath (accept edge)
//   add_en     : accumulate the shifted multiplicand this cycle
//   shift_en   : shift multiplicand left / multiplier right this cycle
//   busy       : high in LOAD, ADD and SHIFT
//   done       : high for the single DONE cycle
// ---------------------------------------------------------------------------
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    input  logic b_zero_now,
    input  logic b_lsb_now,
    input  logic bn_zero,
    input  logic bn_lsb,
    output logic load,
    output logic add_en,
    output logic shift_en,
    output logic busy,
    output logic done
);

    state_t state_q;
    state_t state_d;

    // State register; reset drops any operation in flight back to IDLE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode. The SHIFT decision looks at the
    // post-shift multiplier so that trailing zero bits are skipped without
    // an extra cycle and the operation ends as soon as nothing is left.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (b_zero_now) begin
                    state_d = DONE;
                end else if (b_lsb_now) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD: begin
                busy    = 1'b1;
                add_en  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (bn_zero) begin
                    state_d = DONE;
                end else if (bn_lsb) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : seq_mult_ctrl

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Multi-cycle shift-add multiplier with start/busy/done handshake and early
// termination once the remaining multiplier bits are zero.
// Parameters:
//   WIDTH : operand width (>= 2); product is 2*WIDTH bits
// Ports:
//   clk         : system clock, rising edge
//   clr_n       : asynchronous active-low reset
//   start       : request, accepted only when idle
//   a           : multiplicand, captured on accept
//   b           : multiplier, captured on accept
//   signed_mode : (SEQ_MULT_SIGNED_EN only) treat a/b as two's complement
//   busy        : operation in progress
//   done        : one-cycle pulse, product valid from this cycle on
//   product     : registered result, held until the next result lands
// Optional feature macro: SEQ_MULT_SIGNED_EN
// ---------------------------------------------------------------------------
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0]    a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             neg_in;

    logic load, add_en, shift_en;
    logic b_zero_now, b_lsb_now, bn_zero, bn_lsb;
    logic capture;

`ifdef SEQ_MULT_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // Signed operands are reduced to magnitudes before loading, so the
    // unsigned shift-add core is reused unchanged. The most negative value
    // negates to itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        a_in   = a;
        b_in   = b;
        neg_in = 1'b0;
        if (signed_mode) begin
            if (a[WIDTH-1]) begin
                a_in = ~a + ONE_W;
            end
            if (b[WIDTH-1]) begin
                b_in = ~b + ONE_W;
            end
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_in   = a;
    assign b_in   = b;
    assign neg_in = 1'b0;
`endif

    // Status bits for the controller; bn_* describe the multiplier after
    // the shift that happens in the current SHIFT cycle.
    assign b_zero_now = (b_reg_q == '0);
    assign b_lsb_now  = b_reg_q[0];
    assign bn_zero    = (b_reg_q[WIDTH-1:1] == '0);
    assign bn_lsb     = b_reg_q[1];

    seq_mult_ctrl u_ctrl (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .b_zero_now (b_zero_now),
        .b_lsb_now  (b_lsb_now),
        .bn_zero    (bn_zero),
        .bn_lsb     (bn_lsb),
        .load       (load),
        .add_en     (add_en),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done)
    );

    // The controller is in LOAD when busy but neither adding nor shifting.
    // The edge that moves it into DONE (from LOAD with b==0, or from SHIFT
    // with nothing left) is the edge that registers the product, so the
    // result is already valid during the done pulse.
    assign capture = (busy & ~add_en & ~shift_en & b_zero_now)
                   | (shift_en & bn_zero);

    // Datapath next-state. load/add_en/shift_en are mutually exclusive.
    always_comb begin
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        if (load) begin
            a_reg_d = {{WIDTH{1'b0}}, a_in};
            b_reg_d = b_in;
            acc_d   = '0;
            neg_d   = neg_in;
        end
        if (add_en) begin
            acc_d = acc_q + a_reg_q;
        end
        if (shift_en) begin
            a_reg_d = a_reg_q << 1;
            b_reg_d = b_reg_q >> 1;
        end
        if (capture) begin
            product_d = neg_q ? (~acc_q + ONE_P) : acc_q;
        end
    end

    // Datapath registers; reset also clears the visible product.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Self-checking bench for seq_multiplier (WIDTH=8). Directed cases followed
// by random operands, compared against an arithmetic reference model.
// Honours SEQ_MULT_SIGNED_EN to exercise the signed port.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 40;

    logic                clk;
    logic                clrN;
    logic                start;
    logic [WIDTH-1:0]    opA;
    logic [WIDTH-1:0]    opB;
    logic                signedMode;
    logic                busy;
    logic                done;
    logic [2*WIDTH-1:0]  product;

    int vectors;
    int miscompares;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .clr_n       (clrN),
        .start       (start),
        .a           (opA),
        .b           (opB),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (signedMode),
`endif
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product: plain integer multiplication of the operands as
    // numbers (signed or unsigned), truncated to the product width.
    function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y,
                                               input logic sm);
        int xi, yi;
        if (sm) begin
            xi = int'($signed(x));
            yi = int'($signed(y));
        end else begin
            xi = int'(x);
            yi = int'(y);
        end
        return 16'(xi * yi);
    endfunction

    // Reference latency from accept edge to done cycle: one LOAD cycle,
    // one DONE cycle, one shift per multiplier bit position up to the
    // highest set bit and one add per set bit of the multiplier magnitude.
    function automatic int refLatency(input logic [7:0] y, input logic sm);
        int m, steps, adds;
        m = int'(y);
        if (sm && y[7]) m = 256 - m;
        steps = 0;
        adds  = 0;
        while (m > 0) begin
            if (m % 2 == 1) adds++;
            steps++;
            m = m / 2;
        end
        return 2 + steps + adds;
    endfunction

    // One comparison: counts it, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an operation at a falling edge and return in cycle 1 (LOAD).
    // start stays high afterwards only when holdStart is set.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                                 input logic holdStart);
        opA        = av;
        opB        = bv;
        signedMode = sm;
        start      = 1'b1;
        @(negedge clk);
        if (!holdStart) start = 1'b0;
    endtask

    // Advance until done is seen, bounded; reports the cycle index of done
    // and the number of busy cycles seen before it.
    task automatic waitDone(input int firstCycle, input logic scramble,
                            output int lat, output int busyCnt);
        lat     = firstCycle;
        busyCnt = 0;
        while (!done && lat <= TIMEOUT) begin
            if (busy) busyCnt++;
            if (scramble) begin
                opA = 8'($urandom);
                opB = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (lat > TIMEOUT) checkOutput("doneTimeout", 32'(lat), 32'(TIMEOUT));
    endtask

    // Full operation with checks on latency, busy duration, product and
    // the hold behaviour in the cycle after done.
    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm);
        int lat, busyCnt, expLat;
        logic [15:0] expP;
        expLat = refLatency(bv, sm);
        expP   = refProduct(av, bv, sm);
        applyStimulus(av, bv, sm, 1'b0);
        waitDone(1, 1'b1, lat, busyCnt);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(expLat - 1));
        checkOutput({tag, ".product"}, 32'(product), 32'(expP));
        checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'(0));
        @(negedge clk);
        checkOutput({tag, ".doneDrop"}, 32'(done), 32'(0));
        checkOutput({tag, ".productHold"}, 32'(product), 32'(expP));
    endtask

    // Directed sequence followed by random operations.
    initial begin
        int lat, busyCnt;
        logic [7:0] ra, rb;
        logic rs;

        vectors     = 0;
        miscompares = 0;
        clrN        = 1'b0;
        start       = 1'b0;
        opA         = '0;
        opB         = '0;
        signedMode  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'(0));
        checkOutput("reset.done", 32'(done), 32'(0));
        checkOutput("reset.product", 32'(product), 32'(0));
        clrN = 1'b1;
        @(negedge clk);

        // Directed basics: zero multiplier, typical, worst case.
        runOp("zeroB", 8'hFF, 8'h00, 1'b0);
        runOp("13x11", 8'd13, 8'd11, 1'b0);
        runOp("ffxff", 8'hFF, 8'hFF, 1'b0);

        // start during busy is ignored; start held through done starts the
        // next operation from the following idle cycle.
        applyStimulus(8'd3, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        opA   = 8'd7;
        opB   = 8'd7;
        start = 1'b1;
        waitDone(2, 1'b0, lat, busyCnt);
        checkOutput("ignore.latency", 32'(lat), 32'(refLatency(8'd5, 1'b0)));
        checkOutput("ignore.product", 32'(product), 32'(15));
        @(negedge clk);
        checkOutput("held.idleBusy", 32'(busy), 32'(0));
        checkOutput("held.idleDone", 32'(done), 32'(0));
        @(negedge clk);
        checkOutput("held.accepted", 32'(busy), 32'(1));
        start = 1'b0;
        waitDone(1, 1'b0, lat, busyCnt);
        checkOutput("held.latency", 32'(lat), 32'(refLatency(8'd7, 1'b0)));
        checkOutput("held.product", 32'(product), 32'(49));

        // Reset in the middle of an operation.
        applyStimulus(8'd200, 8'd200, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        clrN = 1'b0;
        #1;
        checkOutput("midReset.busy", 32'(busy), 32'(0));
        checkOutput("midReset.done", 32'(done), 32'(0));
        checkOutput("midReset.product", 32'(product), 32'(0));
        @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);
        runOp("afterReset", 8'd2, 8'd3, 1'b0);

`ifdef SEQ_MULT_SIGNED_EN
        // Signed directed cases, including the most negative operands.
        runOp("sgnNeg3x5", 8'hFD, 8'd5, 1'b1);
        runOp("sgnMin", 8'h80, 8'h80, 1'b1);
        runOp("sgn5xNeg1", 8'd5, 8'hFF, 1'b1);
`endif

        // Random operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            runOp("random", ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq_multiplier
